// File: rtl/epp_bus_bridge.sv
// -----------------------------------------------------------------------------
// epp_bus_bridge
//
// EPP slave sitting behind the USB controller's EPP port. Host EPP address
// cycles load or return an 8-bit address register. Host EPP data cycles become
// single-beat transfers on the internal 8-bit register bus (CYC/STB/WE/ACK).
// There are no tristates here; the parent drives USB_DATA from
// EPP_DATA_OUT whenever EPP_DATA_OE_OUT is high.
//
// Parameters
//   SYNC_STAGES     flops per strobe/direction synchroniser (>= 2)
//   TIMEOUT_CYCLES  clocks spent in BUS without ACK before the transfer is
//                   aborted (1..255)
//   AUTO_INC        1: address + 1 after every data cycle, 0: address held
//
// Ports
//   CLK_IN           in   system clock
//   RST_N_IN         in   asynchronous active-low reset
//   EPP_ASTB_IN      in   EPP address strobe, active-low, asynchronous
//   EPP_DSTB_IN      in   EPP data strobe, active-low, asynchronous
//   EPP_WRITE_IN     in   EPP direction, 0 = host write, 1 = host read
//   EPP_DATA_IN      in   [7:0] EPP data from the pins
//   EPP_DATA_OUT     out  [7:0] EPP read data to the pins
//   EPP_DATA_OE_OUT  out  1 = parent drives USB_DATA with EPP_DATA_OUT
//   EPP_WAIT_OUT     out  EPP wait, 1 = cycle complete
//   BUS_CYC_OUT      out  register bus cycle
//   BUS_STB_OUT      out  register bus strobe (same as CYC)
//   BUS_WE_OUT       out  1 = register write
//   BUS_ADR_OUT      out  [7:0] register address
//   BUS_DAT_WR_OUT   out  [7:0] register write data
//   BUS_DAT_RD_IN    in   [7:0] register read data, sampled on the ACK cycle
//   BUS_ACK_IN       in   single-cycle acknowledge
//   ERR_OUT          out  sticky bus-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module epp_bus_bridge #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit AUTO_INC       = 1'b1
) (
  input  logic       CLK_IN,
  input  logic       RST_N_IN,
  input  logic       EPP_ASTB_IN,
  input  logic       EPP_DSTB_IN,
  input  logic       EPP_WRITE_IN,
  input  logic [7:0] EPP_DATA_IN,
  output logic [7:0] EPP_DATA_OUT,
  output logic       EPP_DATA_OE_OUT,
  output logic       EPP_WAIT_OUT,
  output logic       BUS_CYC_OUT,
  output logic       BUS_STB_OUT,
  output logic       BUS_WE_OUT,
  output logic [7:0] BUS_ADR_OUT,
  output logic [7:0] BUS_DAT_WR_OUT,
  input  logic [7:0] BUS_DAT_RD_IN,
  input  logic       BUS_ACK_IN,
  output logic       ERR_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // The counter starts at 0 on entry to BUS and advances once per BUS clock,
  // so reaching TIMEOUT_CYCLES-1 without ACK means CYC has been high for
  // exactly TIMEOUT_CYCLES clocks.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ADDR_STEP    = {7'd0, AUTO_INC};

  // ---------------------------------------------------------------------------
  // Synchronisers. Strobes idle high, so they reset to 1 to avoid a phantom
  // strobe right after reset. EPP_DATA_IN is not synchronised: the host holds
  // it stable for as long as a strobe is low.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_astb_sync;
  logic [SYNC_STAGES-1:0] r_dstb_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking = here would collapse the chain.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      r_astb_sync <= '1;
      r_dstb_sync <= '1;
      r_wr_sync   <= '1;
    end else begin
      r_astb_sync <= {r_astb_sync[SYNC_STAGES-2:0], EPP_ASTB_IN};
      r_dstb_sync <= {r_dstb_sync[SYNC_STAGES-2:0], EPP_DSTB_IN};
      r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], EPP_WRITE_IN};
    end
  end

  logic w_as;
  logic w_ds;
  logic w_wr;

  assign w_as = r_astb_sync[SYNC_STAGES-1];
  assign w_ds = r_dstb_sync[SYNC_STAGES-1];
  assign w_wr = r_wr_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic       r_hs;       // strobe being served: 0 = ASTB, 1 = DSTB
  logic [7:0] r_addr;
  logic [7:0] r_cnt;
  logic [7:0] r_dout;
  logic       r_oe;
  logic       r_wait;
  logic       r_cyc;
  logic       r_we;
  logic [7:0] r_adr;
  logic [7:0] r_dat_wr;
  logic       r_err;

  state_t     w_state_nxt;
  logic       w_hs_nxt;
  logic [7:0] w_addr_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_dout_nxt;
  logic       w_oe_nxt;
  logic       w_wait_nxt;
  logic       w_cyc_nxt;
  logic       w_we_nxt;
  logic [7:0] w_adr_nxt;
  logic [7:0] w_dat_wr_nxt;
  logic       w_err_nxt;

  logic       w_timeout;
  logic       w_bus_done;
  logic       w_hs_released;

  // ACK wins over a timeout that terminates on the same clock.
  assign w_timeout     = (r_cnt == TIMEOUT_LAST);
  assign w_bus_done    = BUS_ACK_IN || w_timeout;
  assign w_hs_released = r_hs ? w_ds : w_as;

  // ---------------------------------------------------------------------------
  // State register (also holds every registered output)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      r_state  <= ST_IDLE;
      r_hs     <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_oe     <= 1'b0;
      r_wait   <= 1'b0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat_wr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hs     <= w_hs_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dout   <= w_dout_nxt;
      r_oe     <= w_oe_nxt;
      r_wait   <= w_wait_nxt;
      r_cyc    <= w_cyc_nxt;
      r_we     <= w_we_nxt;
      r_adr    <= w_adr_nxt;
      r_dat_wr <= w_dat_wr_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block is what
  // keeps it free of inferred latches when a branch leaves a signal untouched.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        // Address strobe has priority over data strobe.
        if (!w_as)      w_state_nxt = ST_HOLD;
        else if (!w_ds) w_state_nxt = ST_BUS;
      end
      ST_BUS: begin
        if (w_bus_done) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // New strobes are only looked at from IDLE, so a strobe held low
        // keeps us here with WAIT asserted.
        if (w_hs_released) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_hs_nxt     = r_hs;
    w_addr_nxt   = r_addr;
    w_cnt_nxt    = r_cnt;
    w_dout_nxt   = r_dout;
    w_oe_nxt     = r_oe;
    w_wait_nxt   = r_wait;
    w_cyc_nxt    = r_cyc;
    w_we_nxt     = r_we;
    w_adr_nxt    = r_adr;
    w_dat_wr_nxt = r_dat_wr;
    w_err_nxt    = r_err;

    unique case (r_state)
      ST_IDLE: begin
        if (!w_as) begin
          w_hs_nxt   = 1'b0;
          w_wait_nxt = 1'b1;
          if (!w_wr) begin
            w_addr_nxt = EPP_DATA_IN;
          end else begin
            w_dout_nxt = r_addr;
            w_oe_nxt   = 1'b1;
          end
        end else if (!w_ds) begin
          w_hs_nxt     = 1'b1;
          w_cyc_nxt    = 1'b1;
          w_we_nxt     = ~w_wr;
          w_adr_nxt    = r_addr;
          w_dat_wr_nxt = EPP_DATA_IN;
          w_cnt_nxt    = '0;
        end
      end

      ST_BUS: begin
        // Direction was captured into r_we on entry; wr/ds changes here are
        // deliberately ignored.
        if (w_bus_done) begin
          w_cyc_nxt  = 1'b0;
          w_we_nxt   = 1'b0;
          w_wait_nxt = 1'b1;
          w_addr_nxt = r_addr + ADDR_STEP;
          if (!r_we) begin
            // OE rises with WAIT so read data is valid when the host sees WAIT.
            w_oe_nxt   = 1'b1;
            w_dout_nxt = BUS_ACK_IN ? BUS_DAT_RD_IN : 8'hFF;
          end
          if (!BUS_ACK_IN) w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      ST_HOLD: begin
        if (w_hs_released) begin
          w_wait_nxt = 1'b0;
          w_oe_nxt   = 1'b0;
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign EPP_DATA_OUT    = r_dout;
  assign EPP_DATA_OE_OUT = r_oe;
  assign EPP_WAIT_OUT    = r_wait;
  assign BUS_CYC_OUT     = r_cyc;
  assign BUS_STB_OUT     = r_cyc;
  assign BUS_WE_OUT      = r_we;
  assign BUS_ADR_OUT     = r_adr;
  assign BUS_DAT_WR_OUT  = r_dat_wr;
  assign ERR_OUT         = r_err;

endmodule
